// File: rtl/multicycle_control.sv
// Multicycle RV32I control: FETCH/DECODE/EXEC/MEM/WB sequencing, datapath control decode, retire count.
// Controls are combinational from instr; memory waits are bounded by TIMEOUT and trap on expiry (0 = unbounded).
module multicycle_control #(
    parameter int n       = 32,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [n-1:0]     instr,
    input  logic             BrEq,
    input  logic             BrLT,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_is_instr,
    output logic             ir_we,
    output logic             pc_we,
    output logic             RegWEn,
    output logic [2:0]       ImmSel,
    output logic             ALUsrc1,
    output logic             ALUsrc2,
    output logic [3:0]       AluSEL,
    output logic             BrUn,
    output logic [2:0]       ldU,
    output logic [1:0]       WBSel,
    output logic             PCSel,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] instret
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam int WAIT_W = $clog2(TIMEOUT + 1) + 1;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic              r_illegal;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_instret;

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic       w_is_ld, w_is_st, w_is_br, w_legal;
    logic       w_br_take, w_limit, w_set_ill, w_set_to, w_wait_clr;
    logic       w_unused;

    assign w_op     = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_is_ld  = (w_op == OP_LD);
    assign w_is_st  = (w_op == OP_ST);
    assign w_is_br  = (w_op == OP_BR);
    assign w_legal  = (w_op == OP_R) || (w_op == OP_I) || w_is_ld || w_is_st || w_is_br ||
                      (w_op == OP_JAL) || (w_op == OP_JALR) || (w_op == OP_LUI) || (w_op == OP_AUIPC);
    assign w_unused = ^{instr[n-1:31], instr[29:15], instr[11:7]};

    assign state    = r_state;
    assign illegal  = r_illegal;
    assign timeout  = r_timeout;
    assign instret  = r_instret;

    // The limit cycle is the TIMEOUT-th consecutive wait; a ready in that same cycle still completes.
    assign w_limit  = (TIMEOUT > 0) && (r_wait == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        w_br_take = 1'b0;
        case (w_f3)
            3'b000:         w_br_take = BrEq;
            3'b001:         w_br_take = !BrEq;
            3'b100, 3'b110: w_br_take = BrLT;
            3'b101, 3'b111: w_br_take = !BrLT;
            default:        w_br_take = 1'b0;
        endcase
    end

    always_comb begin
        ImmSel  = 3'b000;
        ALUsrc1 = 1'b0;
        ALUsrc2 = 1'b1;
        AluSEL  = 4'b0000;
        BrUn    = 1'b0;
        ldU     = 3'b000;
        WBSel   = 2'b01;
        PCSel   = 1'b0;
        case (w_op)
            OP_R:     begin ALUsrc2 = 1'b0; AluSEL = {instr[30], w_f3}; end
            OP_I:     AluSEL = (w_f3 == 3'b101) ? {instr[30], w_f3} : {1'b0, w_f3};
            OP_LD:    begin ldU = w_f3; WBSel = 2'b00; end
            OP_ST:    begin ImmSel = 3'b001; ldU = w_f3; end
            OP_BR:    begin ImmSel = 3'b010; ALUsrc1 = 1'b1; BrUn = w_f3[1]; PCSel = w_br_take; end
            OP_JAL:   begin ImmSel = 3'b011; ALUsrc1 = 1'b1; WBSel = 2'b10; PCSel = 1'b1; end
            OP_JALR:  begin WBSel = 2'b10; PCSel = 1'b1; end
            OP_LUI:   begin ImmSel = 3'b101; AluSEL = 4'b1111; end
            OP_AUIPC: begin ImmSel = 3'b101; ALUsrc1 = 1'b1; end
            default:  ;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_instr = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        RegWEn       = 1'b0;
        w_set_ill    = 1'b0;
        w_set_to     = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req      = 1'b1;
                mem_is_instr = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_limit) begin
                    w_set_to = 1'b1;
                    w_next   = S_TRAP;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_next = S_EXEC;
                end else begin
                    w_set_ill = 1'b1;
                    w_next    = S_TRAP;
                end
            end
            S_EXEC: begin
                if (w_is_ld || w_is_st) begin
                    w_next = S_MEM;
                end else if (w_is_br) begin
                    pc_we  = 1'b1;
                    w_next = S_FETCH;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = w_is_st;
                if (mem_ready) begin
                    if (w_is_ld) begin
                        w_next = S_WB;
                    end else begin
                        pc_we  = 1'b1;
                        w_next = S_FETCH;
                    end
                end else if (w_limit) begin
                    w_set_to = 1'b1;
                    w_next   = S_TRAP;
                end
            end
            S_WB: begin
                RegWEn = 1'b1;
                pc_we  = 1'b1;
                w_next = S_FETCH;
            end
            default: w_next = S_TRAP;
        endcase
        // Strobes are held off combinationally so a mid-instruction reset writes nothing.
        if (!rst_n) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            RegWEn  = 1'b0;
        end
    end

    assign w_wait_clr = (w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_wait_clr)
                r_wait <= '0;
            else if (mem_req && !mem_ready)
                r_wait <= r_wait + WAIT_W'(1);
            if (w_set_ill)
                r_illegal <= 1'b1;
            if (w_set_to)
                r_timeout <= 1'b1;
            if (pc_we)
                r_instret <= r_instret + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus random instruction streams scored against a
// per-instruction cycle plan built from the state-sequencing rules.
module tb_multicycle_control;
    localparam int TO = 4;
    localparam int CW = 4;

    localparam logic [6:0] LEGAL_OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                             7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    // Per-kind tables, kinds ordered R, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
    localparam logic [2:0] IMM_T [9] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd5, 3'd5};
    localparam logic       SRC1_T [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic       SRC2_T [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam logic [1:0] WB_T [9]   = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1};

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [31:0]   instr = '0;
    logic          BrEq = 1'b0, BrLT = 1'b0, mem_ready = 1'b0;
    logic          mem_req, mem_we, mem_is_instr, ir_we, pc_we, RegWEn;
    logic [2:0]    ImmSel;
    logic          ALUsrc1, ALUsrc2;
    logic [3:0]    AluSEL;
    logic          BrUn;
    logic [2:0]    ldU;
    logic [1:0]    WBSel;
    logic          PCSel;
    logic [2:0]    state;
    logic          illegal, timeout;
    logic [CW-1:0] instret;

    always #5 clk = ~clk;

    multicycle_control #(.n(32), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .BrEq(BrEq), .BrLT(BrLT), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_is_instr(mem_is_instr), .ir_we(ir_we), .pc_we(pc_we),
        .RegWEn(RegWEn), .ImmSel(ImmSel), .ALUsrc1(ALUsrc1), .ALUsrc2(ALUsrc2), .AluSEL(AluSEL),
        .BrUn(BrUn), .ldU(ldU), .WBSel(WBSel), .PCSel(PCSel), .state(state), .illegal(illegal),
        .timeout(timeout), .instret(instret)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int m_cnt;
    bit m_ill, m_to, m_trap;

    typedef struct {
        logic [2:0] st;
        bit req, we, irwe, pcwe, rwe, rdy;
    } cyc_t;
    cyc_t q[$];

    function automatic int kind_of(input logic [31:0] ins);
        for (int i = 0; i < 9; i++)
            if (ins[6:0] == LEGAL_OPS[i]) return i;
        return -1;
    endfunction

    function automatic bit branch_taken(input logic [2:0] f3, input bit eq, input bit lt);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] exp_dp(input logic [31:0] ins, input bit eq, input bit lt);
        int k = kind_of(ins);
        logic [2:0] f3 = ins[14:12];
        logic [3:0] alu = 4'd0;
        logic [2:0] ldu = 3'd0;
        bit brun = 1'b0;
        bit pcs = 1'b0;
        if (k == 0) alu = {ins[30], f3};
        if (k == 1) alu = (f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3};
        if (k == 7) alu = 4'hF;
        if (k == 2 || k == 3) ldu = f3;
        if (k == 4) begin brun = f3[1]; pcs = branch_taken(f3, eq, lt); end
        if (k == 5 || k == 6) pcs = 1'b1;
        return {IMM_T[k], SRC1_T[k], SRC2_T[k], alu, brun, ldu, WB_T[k], pcs};
    endfunction

    function automatic bit rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [2:0] st, input bit req, input bit we, input bit irwe,
                        input bit pcwe, input bit rwe, input bit rdy);
        cyc_t c;
        c.st = st; c.req = req; c.we = we; c.irwe = irwe; c.pcwe = pcwe; c.rwe = rwe; c.rdy = rdy;
        q.push_back(c);
    endtask

    task automatic retire();
        m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    // A memory phase: w idle cycles then a ready cycle, unless the wait budget runs out first.
    task automatic mem_phase(input int w, input bit is_fetch, input bit is_store, output bit ok);
        logic [2:0] st = is_fetch ? 3'd0 : 3'd3;
        ok = 1'b0;
        for (int i = 0; i < w; i++) begin
            push(st, 1, is_store, 0, 0, 0, 0);
            if (i + 1 == TO) begin
                m_to = 1; m_trap = 1;
                push(3'd5, 0, 0, 0, 0, 0, rnd_bit());
                return;
            end
        end
        push(st, 1, is_store, is_fetch, is_store, 0, 1);
        if (is_store) retire();
        ok = 1'b1;
    endtask

    task automatic plan(input logic [31:0] ins, input int wf, input int wm);
        int k = kind_of(ins);
        bit ok;
        q.delete();
        if (m_trap) begin
            repeat (3) push(3'd5, 0, 0, 0, 0, 0, rnd_bit());
            return;
        end
        mem_phase(wf, 1, 0, ok);
        if (!ok) return;
        push(3'd1, 0, 0, 0, 0, 0, rnd_bit());
        if (k < 0) begin
            m_ill = 1; m_trap = 1;
            push(3'd5, 0, 0, 0, 0, 0, rnd_bit());
            return;
        end
        if (k == 4) begin
            push(3'd2, 0, 0, 0, 1, 0, rnd_bit());
            retire();
            return;
        end
        push(3'd2, 0, 0, 0, 0, 0, rnd_bit());
        if (k == 2 || k == 3) begin
            mem_phase(wm, 0, k == 3, ok);
            if (!ok || k == 3) return;
        end
        push(3'd4, 0, 0, 0, 1, 1, rnd_bit());
        retire();
    endtask

    task automatic run(input string tag, input logic [31:0] ins, input bit eq, input bit lt,
                       input int wf, input int wm);
        instr = ins; BrEq = eq; BrLT = lt;
        plan(ins, wf, wm);
        foreach (q[i]) begin
            mem_ready = q[i].rdy;
            @(negedge clk);
            chk({tag, "/ctl"}, 32'({state, mem_req, mem_we, ir_we, pc_we, RegWEn}),
                32'({q[i].st, q[i].req, q[i].we, q[i].irwe, q[i].pcwe, q[i].rwe}));
            if (q[i].req) chk({tag, "/memsel"}, 32'(mem_is_instr), 32'(q[i].st == 3'd0));
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        if (kind_of(ins) >= 0)
            chk({tag, "/dp"}, 32'({ImmSel, ALUsrc1, ALUsrc2, AluSEL, BrUn, ldU, WBSel, PCSel}),
                32'(exp_dp(ins, eq, lt)));
        chk({tag, "/instret"}, 32'(instret), 32'(m_cnt));
        chk({tag, "/flags"}, 32'({illegal, timeout}), 32'({m_ill, m_to}));
        chk({tag, "/end"}, 32'(state), m_trap ? 32'd5 : 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_cnt = 0; m_ill = 0; m_to = 0; m_trap = 0;
        #1;
        chk("rst/ctl", 32'({state, mem_req, mem_we, ir_we, pc_we, RegWEn}), 32'd0);
        chk("rst/regs", 32'({illegal, timeout, instret}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] ins;
        int wf, wm;
        #2;
        do_reset();

        run("addi", 32'h00500093, 0, 0, 0, 0);
        run("bge_ge", 32'h00005063, 0, 0, 0, 0);
        run("bge_lt", 32'h00005063, 0, 1, 0, 0);
        run("sw_wait3", 32'h0020A023, 0, 0, 0, 3);
        run("fetch_ready_at_limit", 32'h00500093, 0, 0, 3, 0);

        // LW abandoned by reset while waiting in MEM
        instr = 32'h0000A083;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("lw/in_mem", 32'(state), 32'd3);
        #1;
        do_reset();

        for (int i = 0; i < 16; i++) run("wrap", 32'h00000063, 1, 0, 0, 0);

        run("illegal", 32'h0000007F, 0, 0, 0, 0);
        run("after_trap", 32'h00500093, 0, 0, 0, 0);
        do_reset();
        run("fetch_timeout", 32'h00500093, 0, 0, 4, 0);
        do_reset();
        run("mem_timeout", 32'h0000A083, 0, 0, 0, 5);
        do_reset();

        for (int t = 0; t < 80; t++) begin
            ins = $urandom;
            if ($urandom_range(0, 19) == 0) begin
                do ins[6:0] = 7'($urandom); while (kind_of(ins) >= 0);
            end else begin
                ins[6:0] = LEGAL_OPS[$urandom_range(0, 8)];
            end
            wf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 5)) : int'($urandom_range(0, 2));
            wm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 5)) : int'($urandom_range(0, 2));
            run("rnd", ins, rnd_bit(), rnd_bit(), wf, wm);
            if (m_trap) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL provide parameter n, default 32, instruction width in bits (n >= 32).
REQ-002 SHALL provide parameter CNT_W, default 32, retired-instruction counter width.
REQ-003 SHALL provide parameter TIMEOUT, default 16, maximum memory-wait cycles; 0 disables the timeout.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 instr  input  n  registered instruction (IR contents); only bits [31:0] are decoded.
REQ-007 BrEq, BrLT  input  1 each  branch comparator results.
REQ-008 mem_ready  input  1  memory completes the current request this cycle.
REQ-009 mem_req, mem_we, mem_is_instr  output  1 each  memory request, write strobe, fetch-versus-data select.
REQ-010 ir_we, pc_we, RegWEn  output  1 each  IR, PC and register-file write enables.
REQ-011 ImmSel[2:0], ALUsrc1, ALUsrc2, AluSEL[3:0], BrUn, ldU[2:0], WBSel[1:0], PCSel  output  datapath controls.
REQ-012 state[2:0], illegal, timeout  output  current state, sticky trap flags.
REQ-013 instret  output  CNT_W  retired-instruction count.

Function
REQ-014 SHALL use states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-015 FETCH: mem_req=1, mem_is_instr=1; on mem_ready, ir_we=1 for that cycle and go to DECODE; otherwise stay.
REQ-016 DECODE: legal opcodes {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111} go to EXEC; any other opcode sets illegal and goes to TRAP.
REQ-017 EXEC: load/store go to MEM; branch asserts pc_we=1, increments instret and goes to FETCH; all other opcodes go to WB.
REQ-018 MEM: mem_req=1, mem_is_instr=0, mem_we=1 for stores only; on mem_ready, a load goes to WB, and a store asserts pc_we=1 with PCSel=0, increments instret and goes to FETCH.
REQ-019 WB: RegWEn=1, pc_we=1, instret+1, then go to FETCH; PCSel=1 for JAL/JALR, otherwise 0.
REQ-020 TRAP: terminal; all write enables and mem_req are 0; exits only on reset.
REQ-021 ir_we, pc_we, RegWEn, mem_req and mem_we SHALL be 0 in every state and cycle not listed above.
REQ-022 Datapath controls SHALL be combinational from instr in every state; don't-care fields SHALL be driven 0.
REQ-023 ImmSel: I=000, S=001, B=010, J=011, U=101.
REQ-024 WBSel: mem=00, ALU=01, PC+4=10; loads use 00, JAL/JALR use 10, all others use 01.
REQ-025 AluSEL:
- R-type: {instr[30], funct3}.
- OP-IMM: {instr[30], funct3} for funct3=101, else {0, funct3}.
- LUI: 1111.
- All others: 0000.
REQ-026 ALUsrc1=1 for AUIPC, JAL and branches; ALUsrc2=1 for every opcode except R-type.
REQ-027 ldU equals funct3 for loads and stores, else 000; BrUn=funct3[1] for branches, else 0.
REQ-028 Branch PCSel=1 when:
- BEQ and BrEq;
- BNE and !BrEq;
- BLT/BLTU and BrLT;
- BGE/BGEU and !BrLT.
Otherwise PCSel=0, including funct3 010/011.
REQ-029 The wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_req=1 && !mem_ready.
REQ-030 If TIMEOUT>0 and the wait count reaches TIMEOUT with mem_ready=0, the block SHALL set timeout and go to TRAP next cycle.
REQ-031 mem_ready in the same cycle as the limit SHALL win over the timeout.
REQ-032 instret SHALL wrap modulo 2^CNT_W.
REQ-033 mem_ready SHALL be ignored outside FETCH and MEM.

Reset
REQ-034 rst_n=0 SHALL immediately force state=FETCH and clear instret, illegal, timeout and the wait counter; outputs follow FETCH decode, with mem_req=0 while rst_n=0.
REQ-035 Reset asserted mid-instruction SHALL abandon it without asserting pc_we or RegWEn.
REQ-036 First FETCH request SHALL be issued the cycle after rst_n rises.

Verification
REQ-037 ADDI x1,x0,5 (0x00500093), mem_ready=1 -> states 0,1,2,4,0; in WB RegWEn=1, AluSEL=0000, WBSel=01, ALUsrc2=1; instret=1.
REQ-038 BGE (funct3=101) with BrLT=0 -> EXEC: PCSel=1, pc_we=1, RegWEn=0; repeat with BrLT=1 -> PCSel=0.
REQ-039 SW (0x0020A023) with mem_ready held 0 for 3 cycles in MEM -> mem_req=1, mem_we=1 held; on ready pc_we=1; total 7 cycles.
REQ-040 Opcode 0x7F -> DECODE to TRAP, illegal=1; further instructions produce no pc_we or RegWEn.
REQ-041 TIMEOUT=4, mem_ready never asserted in FETCH -> TRAP with timeout=1 after the 4th wait cycle; rst_n pulse clears both flags.
REQ-042 Reset asserted during MEM of an LW -> state=0 immediately, no RegWEn; instret preset to all-ones then one retire -> instret=0.
